// File: rtl/control_sequencer_if.sv
// Control sequencer interface: opcode/step inputs from the core, control word back to the datapath.
interface control_sequencer_if #(
   parameter int NUM_T = 6,
   parameter int CNT_W = 8
);
   logic [3:0]       op_code;
   logic             mode_step;
   logic             step_pulse;
   logic [NUM_T-1:0] t_state;
   logic             pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out;
   logic             a_load, a_out, b_load, alu_out, flags_load, out_load;
   logic [2:0]       alu_op;
   logic             halted;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  op_code, mode_step, step_pulse,
      output t_state, pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out,
             a_load, a_out, b_load, alu_out, flags_load, out_load, alu_op, halted, instr_count
   );

   modport slave (
      output op_code, mode_step, step_pulse,
      input  t_state, pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out,
             a_load, a_out, b_load, alu_out, flags_load, out_load, alu_op, halted, instr_count
   );
endinterface

// File: rtl/control_sequencer.sv
// Ring-counter control sequencer for the SAP-style 8-bit core.
// Steps T1..T6 with early return, single-step support, sticky halt and retired-instruction count.
module control_sequencer #(
   parameter int NUM_T = 6,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                low_clr,
   control_sequencer_if.master bus
);

   typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT} state_t;

   typedef enum logic [3:0] {
      OP_LDA = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_XOR = 4'b0011,
      OP_AND = 4'b0100, OP_OR  = 4'b0101, OP_CMP = 4'b0110, OP_LDI = 4'b0111,
      OP_STA = 4'b1000, OP_ADI = 4'b1100, OP_OUT = 4'b1110, OP_HLT = 4'b1111
   } op_t;

   state_t           state, state_nx, last_st;
   logic             adv, gate;
   logic [CNT_W-1:0] count;

   assign adv  = ~bus.mode_step | bus.step_pulse;
   assign gate = adv & low_clr;
   assign bus.instr_count = count;

   // Final T-state of the current opcode; never earlier than T3, so T1/T2 ignore the opcode
   always_comb begin
      case (bus.op_code)
         OP_LDA, OP_STA, OP_ADI:                         last_st = T5;
         OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP:  last_st = T6;
         OP_LDI, OP_OUT, OP_HLT:                         last_st = T4;
         default:                                        last_st = T3;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!low_clr) state <= T1;
      else          state <= state_nx;
   end

   // Retired-instruction counter, bumped on the edge that leaves an instruction's final step
   always_ff @(posedge clk) begin
      if (!low_clr)                                     count <= '0;
      else if (adv && state != HALT && state == last_st) count <= count + 1'b1;
   end

   // Next-state: advance on adv, return to T1 after the final step, HLT parks in HALT
   always_comb begin
      state_nx = state;
      if (adv && state != HALT) begin
         if (state == last_st) begin
            state_nx = (bus.op_code == OP_HLT) ? HALT : T1;
         end else begin
            case (state)
               T1:      state_nx = T2;
               T2:      state_nx = T3;
               T3:      state_nx = T4;
               T4:      state_nx = T5;
               T5:      state_nx = T6;
               default: state_nx = T1;
            endcase
         end
      end
   end

   // Control word decode: strobes gated by advance and reset, alu_op only by reset
   always_comb begin
      bus.pc_out     = 1'b0;
      bus.pc_inc     = 1'b0;
      bus.mar_load   = 1'b0;
      bus.ram_out    = 1'b0;
      bus.ram_write  = 1'b0;
      bus.ir_load    = 1'b0;
      bus.ir_out     = 1'b0;
      bus.a_load     = 1'b0;
      bus.a_out      = 1'b0;
      bus.b_load     = 1'b0;
      bus.alu_out    = 1'b0;
      bus.flags_load = 1'b0;
      bus.out_load   = 1'b0;
      bus.alu_op     = 3'b000;
      bus.halted     = low_clr && (state == HALT);
      for (int unsigned i = 0; i < unsigned'(NUM_T); i++) begin
         bus.t_state[i] = (state != HALT) && (32'(state) == i);
      end
      if (low_clr) begin
         case (state)
            T1: begin
               bus.pc_out   = gate;
               bus.mar_load = gate;
            end
            T2: bus.pc_inc = gate;
            T3: begin
               bus.ram_out = gate;
               bus.ir_load = gate;
            end
            T4: begin
               case (bus.op_code)
                  OP_LDA, OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP, OP_STA: begin
                     bus.ir_out   = gate;
                     bus.mar_load = gate;
                  end
                  OP_LDI: begin
                     bus.ir_out = gate;
                     bus.a_load = gate;
                  end
                  OP_ADI: begin
                     bus.ir_out = gate;
                     bus.b_load = gate;
                  end
                  OP_OUT: begin
                     bus.a_out    = gate;
                     bus.out_load = gate;
                  end
                  default: ;
               endcase
            end
            T5: begin
               case (bus.op_code)
                  OP_LDA: begin
                     bus.ram_out = gate;
                     bus.a_load  = gate;
                  end
                  OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR, OP_CMP: begin
                     bus.ram_out = gate;
                     bus.b_load  = gate;
                  end
                  OP_ADI: begin
                     bus.alu_out    = gate;
                     bus.a_load     = gate;
                     bus.flags_load = gate;
                  end
                  OP_STA: begin
                     bus.a_out     = gate;
                     bus.ram_write = gate;
                  end
                  default: ;
               endcase
            end
            T6: begin
               case (bus.op_code)
                  OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR: begin
                     bus.alu_out    = gate;
                     bus.a_load     = gate;
                     bus.flags_load = gate;
                     bus.alu_op     = 3'(bus.op_code - 4'd1);
                  end
                  OP_CMP: begin
                     bus.flags_load = gate;
                     bus.alu_op     = 3'b001;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Ring-counter-based control sequencer for the SAP-style 8-bit core.
- Generates the one-hot T-state and the per-cycle control word (bus drivers, register loads, ALU op, RAM write) from the instruction register opcode.
- Drives the PC, MAR, RAM, IR, A, B, ALU, flags and output register.
- Supports free-run and single-step modes, a sticky halt, and a retired-instruction counter.

Parameters:
- NUM_T, 6, number of T-states in the ring (T1..T6).
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- low_clr  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- op_code  in  4  IR upper nibble; must be stable from the T3 edge onward.
- mode_step  in  1  1 = single-step mode, 0 = free-run.
- step_pulse  in  1  in step mode, advance one T-state on a cycle where this is high.
- t_state  out  NUM_T  one-hot current T-state; bit0 = T1.
- pc_out, pc_inc, mar_load, ram_out, ram_write, ir_load, ir_out  out  1 each  control strobes.
- a_load, a_out, b_load, alu_out, flags_load, out_load  out  1 each  control strobes.
- alu_op  out  3  ALU operation: 000 add, 001 sub, 010 xor, 011 and, 100 or.
- halted  out  1  high once HLT has executed.
- instr_count  out  CNT_W  number of completed instructions; wraps.

Behaviour:
- Opcode map:
  - 0000 LDA, 0001 ADD, 0010 SUB, 0011 XOR, 0100 AND, 0101 OR, 0110 CMP, 0111 LDI.
  - 1000 STA, 1100 ADI, 1110 OUT, 1111 HLT.
  - All other opcodes are NOP.
- Advance enable: adv = ~mode_step | step_pulse.
  - The state machine moves only when adv = 1.
  - Every strobe is ANDed with adv, so no load or increment repeats while stalled.
  - alu_op is not gated.
- While low_clr = 0:
  - all strobes = 0, alu_op = 000, halted = 0;
  - t_state <= 000001 and instr_count <= 0 at the edge.
- A reset mid-instruction aborts it. The first cycle after release is T1 of a fresh fetch.
- Fetch sequence, common to all opcodes:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- Execute steps (ir_out places the IR low nibble on the bus, zero-extended):
  - LDA: T4 ir_out+mar_load; T5 ram_out+a_load.
  - ADD/SUB/XOR/AND/OR: T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load+flags_load, alu_op per op.
  - CMP: same as SUB, but T6 asserts flags_load only, with alu_op = 001 and no a_load or alu_out.
  - LDI: T4 ir_out+a_load.
  - ADI: T4 ir_out+b_load; T5 alu_out+a_load+flags_load, alu_op = 000.
  - STA: T4 ir_out+mar_load; T5 a_out+ram_write.
  - OUT: T4 a_out+out_load.
  - NOP: no execute steps.
  - HLT: T4 sets halted; no strobes.
- Early return: after an instruction's last active step, the next advance goes to T1.
  - Instruction lengths: NOP 3, LDI/OUT 4, LDA/ADI/STA 5, ALU ops and CMP 6 T-states.
  - Unused T-states are never visited.
- instr_count increments by 1 on the advancing edge that leaves the final step; it wraps from 2^CNT_W-1 to 0.
- HLT behaviour:
  - instr_count increments once.
  - halted <= 1 and t_state <= 0 (all-zero).
  - All strobes stay 0 and step_pulse is ignored.
  - Only low_clr exits the halt.
- alu_op is 000 whenever no ALU step is active.
- Outputs are combinational from the registered state, op_code and adv; there are no registered output delays.

Test Plan:
- Reset, then free-run with NOP (0001 is ADD, so use 1001) -> t_state 000001, 000010, 000100, 000001; strobes pc_out+mar_load, pc_inc, ram_out+ir_load; instr_count = 1 after cycle 3.
- ADD (0001), free-run -> T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load+flags_load with alu_op = 000; back to T1 on cycle 7.
- CMP (0110) -> T6 flags_load = 1, alu_op = 001, a_load = 0, alu_out = 0. STA (1000) -> T5 a_out+ram_write, then T1.
- mode_step = 1, pulse step_pulse every 4th cycle during LDA -> t_state changes only on pulse edges; pc_inc high for exactly 1 cycle; count +1 after the 5th pulse.
- HLT (1111) -> halted = 1, t_state = 0, all strobes 0 for 20 cycles regardless of step_pulse; low_clr low for 1 cycle -> halted = 0, t_state = 000001.
- low_clr asserted at T5 of ADD -> no a_load at any point; the next cycle after release is T1; instr_count = 0. Separately, execute 256 NOPs -> instr_count wraps to 0.
